// File: rtl/ap_drv_pkg.sv
// Shared types and defaults for the HLS ap_ctrl initiator (ap_ctrl_driver).
package ap_drv_pkg;

  localparam int TXN_W_DEF           = 16;
  localparam int MAX_OUTSTANDING_DEF = 2;
  localparam int TIMEOUT_CYCLES_DEF  = 100000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } ap_drv_state_e;

  typedef logic [TXN_W_DEF-1:0] count_t;

  // RUN and DRAIN are the states that talk to the kernel
  function automatic logic is_active(input ap_drv_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/ap_ctrl_driver_if.sv
// HLS block-level control handshake between the initiator (master) and the kernel (slave).
interface ap_ctrl_driver_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (output ap_start, output ap_continue, input ap_ready, input ap_done);
  modport slave  (input ap_start, input ap_continue, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_drv_watchdog.sv
// Progress watchdog for ap_ctrl_driver; the module only exists when AP_DRV_WATCHDOG_EN is defined.
`ifdef AP_DRV_WATCHDOG_EN
module ap_drv_watchdog
  import ap_drv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count stalled cycles; any progress or leaving the active states restarts it
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_en & ~i_clr & (r_cnt == LIMIT);

endmodule
`endif

// File: rtl/ap_ctrl_driver.sv
// Initiator for the HLS ap_start/ap_ready/ap_done/ap_continue protocol: runs N transactions.
// Optional stall watchdog enabled by defining AP_DRV_WATCHDOG_EN.
module ap_ctrl_driver
  import ap_drv_pkg::*;
#(
  parameter int TXN_W           = TXN_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [TXN_W-1:0]   cmd_count,
  ap_ctrl_driver_if.master   ap,
  output logic               busy,
  output logic               finish,
  output logic [TXN_W-1:0]   started_count,
  output logic [TXN_W-1:0]   done_count,
  output logic               err_proto,
  output logic               err_timeout
);

  localparam logic [TXN_W-1:0] MAX_OUT_C = TXN_W'(MAX_OUTSTANDING);

  ap_drv_state_e    r_state, w_state_next;
  logic [TXN_W-1:0] r_count, r_started, r_done;
  logic             r_ap_start, r_ap_continue, r_busy, r_finish, r_err_proto;
  logic             w_accept, w_start_acc, w_done_seen, w_done_cnt, w_spurious, w_timeout;
  logic             w_ap_start_next;
  logic [TXN_W-1:0] w_outstanding, w_outstanding_next, w_started_next, w_done_next;

  assign cmd_ready = (r_state == IDLE);
  assign w_accept  = cmd_valid & cmd_ready;

  assign w_start_acc        = r_ap_start & ap.ap_ready;
  assign w_done_seen        = ap.ap_done & r_ap_continue;
  assign w_outstanding      = r_started - r_done;
  // a done is only legitimate against something in flight, including a start accepted this cycle
  assign w_done_cnt         = w_done_seen & ((w_outstanding != '0) | w_start_acc);
  assign w_spurious         = w_done_seen & ~w_done_cnt;
  assign w_started_next     = r_started + TXN_W'(w_start_acc);
  assign w_done_next        = r_done + TXN_W'(w_done_cnt);
  assign w_outstanding_next = w_started_next - w_done_next;

  // Next state and next ap_start
  always_comb begin
    w_state_next    = r_state;
    w_ap_start_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_count == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next    = RUN;
            w_ap_start_next = 1'b1;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_timeout) begin
          w_state_next = ERROR;
        end else if (w_done_next == r_count) begin
          w_state_next = DONE;
        end else if (w_started_next == r_count) begin
          w_state_next = DRAIN;
        end else begin
          w_state_next    = RUN;
          w_ap_start_next = (w_outstanding_next < MAX_OUT_C);
        end
      end
      DRAIN: begin
        if (w_timeout) begin
          w_state_next = ERROR;
        end else if (w_done_next == r_count) begin
          w_state_next = DONE;
        end else begin
          w_state_next = DRAIN;
        end
      end
      DONE:    w_state_next = IDLE;
      ERROR:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, handshake outputs and run counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ap_start    <= 1'b0;
      r_ap_continue <= 1'b0;
      r_busy        <= 1'b0;
      r_finish      <= 1'b0;
      r_count       <= '0;
      r_started     <= '0;
      r_done        <= '0;
      r_err_proto   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ap_start    <= w_ap_start_next;
      r_ap_continue <= is_active(w_state_next);
      r_busy        <= is_active(w_state_next);
      // finish trails the terminal state by one cycle
      r_finish      <= (r_state == DONE) || (r_state == ERROR);
      if (w_accept) begin
        r_count     <= cmd_count;
        r_started   <= '0;
        r_done      <= '0;
        r_err_proto <= 1'b0;
      end else begin
        r_started   <= w_started_next;
        r_done      <= w_done_next;
        r_err_proto <= r_err_proto | w_spurious;
      end
    end
  end

  assign ap.ap_start    = r_ap_start;
  assign ap.ap_continue = r_ap_continue;
  assign busy           = r_busy;
  assign finish         = r_finish;
  assign started_count  = r_started;
  assign done_count     = r_done;
  assign err_proto      = r_err_proto;

`ifdef AP_DRV_WATCHDOG_EN
  logic r_err_timeout;

  ap_drv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_en     (r_busy),
    .i_clr    (w_start_acc | w_done_cnt),
    .o_expired(w_timeout)
  );

  // Sticky timeout flag, cleared by a new run
  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_err_timeout <= 1'b1;
    end else begin
      r_err_timeout <= r_err_timeout;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

endmodule
